// File: rtl/nasti_read_burst_splitter_pkg.sv
// Shared NASTI read-request definitions: captured AR control fields, FSM encodings
// and the sub-burst sizing helper.
package nasti_read_burst_splitter_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } NastiReq;

    // Beats that fit between offset and the next max_bytes boundary, capped at rem.
    function automatic logic [8:0] chunk_beats(input logic [12:0] offset,
                                               input logic [2:0]  size,
                                               input logic [12:0] max_bytes,
                                               input logic [8:0]  rem);
        logic [12:0] room;
        room = (max_bytes - offset) >> size;
        if (room > {4'd0, rem})
            return rem;
        return room[8:0];
    endfunction

endpackage

// File: rtl/nasti_read_burst_splitter.sv
// Splits one INCR read burst into sub-bursts that never cross a MAX_BYTES boundary,
// stitching the returned data back into a single upstream burst.
module nasti_read_burst_splitter
    import nasti_read_burst_splitter_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BYTES  = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   master_ar_id,
    input  logic [ADDR_WIDTH-1:0] master_ar_addr,
    input  logic [7:0]            master_ar_len,
    input  logic [2:0]            master_ar_size,
    input  logic [1:0]            master_ar_burst,
    input  logic                  master_ar_lock,
    input  logic [3:0]            master_ar_cache,
    input  logic [2:0]            master_ar_prot,
    input  logic [3:0]            master_ar_qos,
    input  logic [3:0]            master_ar_region,
    input  logic [USER_WIDTH-1:0] master_ar_user,
    input  logic                  master_ar_valid,
    output logic                  master_ar_ready,
    output logic [ID_WIDTH-1:0]   master_r_id,
    output logic [DATA_WIDTH-1:0] master_r_data,
    output logic [1:0]            master_r_resp,
    output logic                  master_r_last,
    output logic [USER_WIDTH-1:0] master_r_user,
    output logic                  master_r_valid,
    input  logic                  master_r_ready,
    output logic [ID_WIDTH-1:0]   slave_ar_id,
    output logic [ADDR_WIDTH-1:0] slave_ar_addr,
    output logic [7:0]            slave_ar_len,
    output logic [2:0]            slave_ar_size,
    output logic [1:0]            slave_ar_burst,
    output logic                  slave_ar_lock,
    output logic [3:0]            slave_ar_cache,
    output logic [2:0]            slave_ar_prot,
    output logic [3:0]            slave_ar_qos,
    output logic [3:0]            slave_ar_region,
    output logic [USER_WIDTH-1:0] slave_ar_user,
    output logic                  slave_ar_valid,
    input  logic                  slave_ar_ready,
    input  logic [ID_WIDTH-1:0]   slave_r_id,
    input  logic [DATA_WIDTH-1:0] slave_r_data,
    input  logic [1:0]            slave_r_resp,
    input  logic                  slave_r_last,
    input  logic [USER_WIDTH-1:0] slave_r_user,
    input  logic                  slave_r_valid,
    output logic                  slave_r_ready
);

    localparam logic [12:0]           MB13    = 13'(MAX_BYTES);
    localparam logic [ADDR_WIDTH-1:0] MB_ADDR = ADDR_WIDTH'(MAX_BYTES);

    logic [1:0]            state;
    NastiReq               req;
    logic [ID_WIDTH-1:0]   req_id;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [USER_WIDTH-1:0] req_user;
    logic [8:0]            rem;
    logic [8:0]            sub_left;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  first;

    logic [12:0]           first_offset;
    logic [8:0]            beats;
    logic [8:0]            beats_m1;
    logic [ADDR_WIDTH-1:0] next_boundary;
    logic                  in_r;
    logic                  r_hs;

    // Only the first chunk can start mid-window; later ones begin on a boundary.
    assign first_offset  = req_addr[12:0] & ~((13'd1 << req.size) - 13'd1) & (MB13 - 13'd1);
    assign beats         = chunk_beats(first ? first_offset : 13'd0, req.size, MB13, rem);
    assign beats_m1      = beats - 9'd1;
    assign next_boundary = (slave_ar_addr & ~(MB_ADDR - ADDR_WIDTH'(1))) + MB_ADDR;
    assign in_r          = (state == S_R);
    assign r_hs          = in_r && slave_r_valid && master_r_ready;

    assign master_ar_ready = (state == S_IDLE) && rstn;

    assign slave_ar_valid  = (state == S_AR);
    assign slave_ar_id     = req_id;
    assign slave_ar_addr   = first ? req_addr : cur_addr;
    assign slave_ar_len    = beats_m1[7:0];
    assign slave_ar_size   = req.size;
    assign slave_ar_burst  = req.burst;
    assign slave_ar_lock   = req.lock;
    assign slave_ar_cache  = req.cache;
    assign slave_ar_prot   = req.prot;
    assign slave_ar_qos    = req.qos;
    assign slave_ar_region = req.region;
    assign slave_ar_user   = req_user;

    assign master_r_valid = in_r && slave_r_valid;
    assign slave_r_ready  = in_r && master_r_ready;
    assign master_r_id    = req_id;
    assign master_r_data  = slave_r_data;
    assign master_r_resp  = slave_r_resp;
    assign master_r_user  = slave_r_user;
    assign master_r_last  = in_r && slave_r_last && (rem == 9'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            req      <= '0;
            req_id   <= '0;
            req_addr <= '0;
            req_user <= '0;
            rem      <= '0;
            sub_left <= '0;
            cur_addr <= '0;
            first    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (master_ar_valid) begin
                    req      <= '{len: master_ar_len, size: master_ar_size,
                                  burst: master_ar_burst, lock: master_ar_lock,
                                  cache: master_ar_cache, prot: master_ar_prot,
                                  qos: master_ar_qos, region: master_ar_region};
                    req_id   <= master_ar_id;
                    req_addr <= master_ar_addr;
                    req_user <= master_ar_user;
                    rem      <= {1'b0, master_ar_len} + 9'd1;
                    first    <= 1'b1;
                    state    <= S_AR;
                end
                S_AR: if (slave_ar_ready) begin
                    rem      <= rem - beats;
                    sub_left <= beats;
                    cur_addr <= next_boundary;
                    first    <= 1'b0;
                    state    <= S_R;
                end
                S_R: if (r_hs) begin
                    sub_left <= sub_left - 9'd1;
                    if (slave_r_last)
                        state <= (rem == 9'd0) ? S_IDLE : S_AR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Protocol guards: unsupported requests and a downstream that ends a sub-burst early.
    always_ff @(posedge clk) begin
        if (rstn && master_ar_valid && master_ar_ready)
            assert (master_ar_burst == BURST_INCR && (int'(1) << master_ar_size) <= DATA_WIDTH / 8)
                else $fatal(1, "unsupported AR: burst=%0d size=%0d", master_ar_burst, master_ar_size);
        if (rstn && r_hs && slave_r_last)
            assert (sub_left == 9'd1)
                else $fatal(1, "slave_r_last early, %0d beats still expected", sub_left);
    end

endmodule

// File: tb/tb_nasti_read_burst_splitter.sv
// Randomized bench: a byte-window model predicts the sub-bursts, a slave responder
// returns random data, and every upstream beat is checked against what was sent.
module tb_nasti_read_burst_splitter;

    localparam int MB = 128;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  master_ar_id;
    logic [31:0] master_ar_addr;
    logic [7:0]  master_ar_len;
    logic [2:0]  master_ar_size;
    logic [1:0]  master_ar_burst;
    logic        master_ar_lock;
    logic [3:0]  master_ar_cache;
    logic [2:0]  master_ar_prot;
    logic [3:0]  master_ar_qos;
    logic [3:0]  master_ar_region;
    logic [0:0]  master_ar_user;
    logic        master_ar_valid;
    logic        master_ar_ready;
    logic [1:0]  master_r_id;
    logic [63:0] master_r_data;
    logic [1:0]  master_r_resp;
    logic        master_r_last;
    logic [0:0]  master_r_user;
    logic        master_r_valid;
    logic        master_r_ready;
    logic [1:0]  slave_ar_id;
    logic [31:0] slave_ar_addr;
    logic [7:0]  slave_ar_len;
    logic [2:0]  slave_ar_size;
    logic [1:0]  slave_ar_burst;
    logic        slave_ar_lock;
    logic [3:0]  slave_ar_cache;
    logic [2:0]  slave_ar_prot;
    logic [3:0]  slave_ar_qos;
    logic [3:0]  slave_ar_region;
    logic [0:0]  slave_ar_user;
    logic        slave_ar_valid;
    logic        slave_ar_ready;
    logic [1:0]  slave_r_id;
    logic [63:0] slave_r_data;
    logic [1:0]  slave_r_resp;
    logic        slave_r_last;
    logic [0:0]  slave_r_user;
    logic        slave_r_valid;
    logic        slave_r_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } sub_t;
    sub_t exp_q[$];

    nasti_read_burst_splitter #(
        .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1), .MAX_BYTES(MB)
    ) dut (
        .clk(clk), .rstn(rstn),
        .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr),
        .master_ar_len(master_ar_len), .master_ar_size(master_ar_size),
        .master_ar_burst(master_ar_burst), .master_ar_lock(master_ar_lock),
        .master_ar_cache(master_ar_cache), .master_ar_prot(master_ar_prot),
        .master_ar_qos(master_ar_qos), .master_ar_region(master_ar_region),
        .master_ar_user(master_ar_user), .master_ar_valid(master_ar_valid),
        .master_ar_ready(master_ar_ready),
        .master_r_id(master_r_id), .master_r_data(master_r_data),
        .master_r_resp(master_r_resp), .master_r_last(master_r_last),
        .master_r_user(master_r_user), .master_r_valid(master_r_valid),
        .master_r_ready(master_r_ready),
        .slave_ar_id(slave_ar_id), .slave_ar_addr(slave_ar_addr),
        .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
        .slave_ar_burst(slave_ar_burst), .slave_ar_lock(slave_ar_lock),
        .slave_ar_cache(slave_ar_cache), .slave_ar_prot(slave_ar_prot),
        .slave_ar_qos(slave_ar_qos), .slave_ar_region(slave_ar_region),
        .slave_ar_user(slave_ar_user), .slave_ar_valid(slave_ar_valid),
        .slave_ar_ready(slave_ar_ready),
        .slave_r_id(slave_r_id), .slave_r_data(slave_r_data),
        .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
        .slave_r_user(slave_r_user), .slave_r_valid(slave_r_valid),
        .slave_r_ready(slave_r_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte-level view: walk the burst, cutting it wherever a MB window ends.
    task automatic build_model(input logic [31:0] addr, input int size, input int len);
        longint b, a, cur, remaining, beats;
        sub_t   s;
        exp_q.delete();
        b         = longint'(1) << size;
        remaining = len + 1;
        a         = (longint'(addr) / b) * b;
        cur       = longint'(addr);
        while (remaining > 0) begin
            beats = (MB - (a % MB)) / b;
            if (beats > remaining) beats = remaining;
            s.addr = cur[31:0];
            s.len  = int'(beats) - 1;
            exp_q.push_back(s);
            remaining -= beats;
            a   = (a / MB + 1) * MB;
            cur = a;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input int size, input int len,
                                  input bit stall, input int abort_sub);
        int          total, beat, sub_left, sub_idx, beats_in_sub, cycles;
        bit          outstanding, ar_taken, aborted;
        logic [63:0] cur_data;
        logic [1:0]  cur_resp;
        logic [1:0]  id;
        sub_t        e;

        build_model(addr, size, len);
        id               = 2'($urandom);
        master_ar_id     = id;
        master_ar_addr   = addr;
        master_ar_len    = 8'(len);
        master_ar_size   = 3'(size);
        master_ar_burst  = 2'b01;
        master_ar_lock   = 1'($urandom);
        master_ar_cache  = 4'($urandom);
        master_ar_prot   = 3'($urandom);
        master_ar_qos    = 4'($urandom);
        master_ar_region = 4'($urandom);
        master_ar_user   = 1'($urandom);
        master_ar_valid  = 1'b1;

        total = len + 1; beat = 0; sub_left = 0; sub_idx = 0; beats_in_sub = 0;
        cycles = 0; ar_taken = 0; aborted = 0;
        cur_data = {$urandom, $urandom};
        cur_resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;

        while (beat < total && cycles < 4000 && !aborted) begin
            cycles++;
            slave_ar_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            master_r_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            slave_r_valid  = (sub_left > 0) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            slave_r_data   = cur_data;
            slave_r_resp   = cur_resp;
            slave_r_last   = (sub_left == 1);
            slave_r_id     = 2'($urandom);
            slave_r_user   = 1'($urandom);

            @(negedge clk);
            outstanding = (sub_left > 0);
            check_output("r_valid_mirror", 64'(master_r_valid), outstanding ? 64'(slave_r_valid) : 64'd0);
            check_output("r_ready_mirror", 64'(slave_r_ready), outstanding ? 64'(master_r_ready) : 64'd0);
            if (outstanding)
                check_output("one_outstanding", 64'(slave_ar_valid), 64'd0);
            if (master_ar_valid && master_ar_ready)
                ar_taken = 1;

            if (slave_ar_valid && slave_ar_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("extra_sub_burst", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sub_addr", 64'(slave_ar_addr), 64'(e.addr));
                    check_output("sub_len", 64'(slave_ar_len), 64'(e.len));
                    check_output("sub_id", 64'(slave_ar_id), 64'(id));
                    check_output("sub_size", 64'(slave_ar_size), 64'(size));
                    check_output("sub_fields", {slave_ar_burst, slave_ar_prot, slave_ar_cache, slave_ar_qos},
                                 {master_ar_burst, master_ar_prot, master_ar_cache, master_ar_qos});
                    sub_left = e.len + 1;
                    sub_idx++;
                    beats_in_sub = 0;
                end
            end

            if (slave_r_valid && slave_r_ready) begin
                check_output("r_data", master_r_data, cur_data);
                check_output("r_resp", 64'(master_r_resp), 64'(cur_resp));
                check_output("r_id", 64'(master_r_id), 64'(id));
                check_output("r_last", 64'(master_r_last), 64'(beat == total - 1));
                beat++;
                sub_left--;
                beats_in_sub++;
                cur_data = {$urandom, $urandom};
                cur_resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            end

            @(posedge clk); #1;
            if (ar_taken) master_ar_valid = 1'b0;

            if (abort_sub != 0 && sub_idx == abort_sub && beats_in_sub == 3) begin
                aborted        = 1;
                slave_r_valid  = 1'b1;
                master_r_ready = 1'b1;
                slave_ar_ready = 1'b1;
                rstn = 1'b0;
                #1;
                check_output("rst_ar_ready", 64'(master_ar_ready), 64'd0);
                check_output("rst_slave_ar_valid", 64'(slave_ar_valid), 64'd0);
                check_output("rst_r_valid", 64'(master_r_valid), 64'd0);
                check_output("rst_r_ready", 64'(slave_r_ready), 64'd0);
                slave_r_valid = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rstn = 1'b1;
                #1;
                check_output("post_rst_ar_ready", 64'(master_ar_ready), 64'd1);
                @(posedge clk); #1;
            end
        end

        slave_r_valid   = 1'b0;
        master_ar_valid = 1'b0;
        if (!aborted) begin
            if (beat < total) check_output("timeout_beats", 64'(beat), 64'(total));
            check_output("subs_remaining", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            check_output("back_to_idle", 64'(master_ar_ready), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rstn = 1'b0;
        master_ar_valid = 0; master_ar_id = 0; master_ar_addr = 0; master_ar_len = 0;
        master_ar_size = 0; master_ar_burst = 2'b01; master_ar_lock = 0; master_ar_cache = 0;
        master_ar_prot = 0; master_ar_qos = 0; master_ar_region = 0; master_ar_user = 0;
        master_r_ready = 0; slave_ar_ready = 0;
        slave_r_id = 0; slave_r_data = 0; slave_r_resp = 0; slave_r_last = 0;
        slave_r_user = 0; slave_r_valid = 0;

        #3;
        check_output("reset_ar_ready", 64'(master_ar_ready), 64'd0);
        check_output("reset_slave_ar_valid", 64'(slave_ar_valid), 64'd0);
        check_output("reset_r_valid", 64'(master_r_valid), 64'd0);
        check_output("reset_r_ready", 64'(slave_r_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] aligned 64-beat burst");
        apply_stimulus(32'h1000, 3, 63, 0, 0);
        $display("[TB] mid-window start");
        apply_stimulus(32'h1040, 3, 31, 0, 0);
        $display("[TB] single unaligned beat");
        apply_stimulus(32'h1004, 3, 0, 0, 0);
        $display("[TB] 4KB page edge");
        apply_stimulus(32'h1F80, 2, 40, 0, 0);
        $display("[TB] stalled 64-beat burst");
        apply_stimulus(32'h1000, 3, 63, 1, 0);
        $display("[TB] reset during second sub-burst");
        apply_stimulus(32'h1000, 3, 63, 0, 2);
        $display("[TB] random bursts");
        for (int i = 0; i < 25; i++)
            apply_stimulus($urandom_range(0, 32'hFFFF), $urandom_range(0, 3),
                           $urandom_range(0, 255), 1'($urandom), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/nasti_read_burst_splitter.md
NASTI_READ_BURST_SPLITTER -- requirements
Module: nasti_read_burst_splitter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2: NASTI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: R data width, same on both sides.
REQ-004 SHALL have parameter USER_WIDTH, default 1: USER field width.
REQ-005 SHALL have parameter MAX_BYTES, default 128: maximum bytes per sub-burst; power of two, at least DATA_WIDTH/8, at most 4096.
REQ-006 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have the master_ar_* group (id, addr, len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4], region[4], user, valid as inputs; ready as output): upstream read request.
REQ-009 SHALL have the master_r_* group (id, data[DATA_WIDTH], resp[2], last, user, valid as outputs; ready as input): upstream read data.
REQ-010 SHALL have the slave_ar_* group, mirroring REQ-008 with directions reversed: downstream sub-burst request, feeding nasti_narrower_reader.
REQ-011 SHALL have the slave_r_* group, mirroring REQ-009 with directions reversed: downstream read data.

Function
REQ-012 SHALL split one INCR burst into sub-bursts, none of which crosses a MAX_BYTES-aligned boundary.
REQ-013 SHALL keep at most one master transaction and one sub-burst outstanding.
REQ-014 SHALL use FSM states S_IDLE, S_AR and S_R with these transitions:
  - S_IDLE to S_AR on master AR handshake.
  - S_AR to S_R on slave AR handshake.
  - S_R to S_AR on a slave R handshake with slave_r_last=1 while beats remain.
  - S_R to S_IDLE on a slave R handshake with slave_r_last=1 and no beats remaining.
REQ-015 SHALL drive master_ar_ready=1 only in S_IDLE, and SHALL capture all AR fields into a NastiReq register on the master AR handshake.
REQ-016 SHALL use remaining-beat counter rem[8:0], loaded with len+1 on master AR, and decremented by the sub-burst beat count on each slave AR handshake.
REQ-017 SHALL use beat size B=1<<size and aligned address A=addr with bits [size-1:0] cleared.
REQ-018 SHALL compute first-chunk beats as (MAX_BYTES - A mod MAX_BYTES)/B; later chunks use MAX_BYTES/B; each chunk is capped at rem.
REQ-019 SHALL drive slave_ar_addr as follows:
  - first sub-burst: the original, possibly unaligned, addr;
  - later sub-bursts: the next MAX_BYTES-aligned address, held in the cur_addr register.
REQ-020 SHALL drive slave_ar_len = chunk beats - 1; all other AR fields equal the captured values; slave_ar_valid=1 only in S_AR.
REQ-021 SHALL pass R through combinationally in S_R:
  - master_r_valid=slave_r_valid;
  - slave_r_ready=master_r_ready;
  - data, resp and user are copied.
REQ-022 SHALL force both master_r_valid and slave_r_ready to 0 outside S_R.
REQ-023 SHALL drive master_r_last = slave_r_last AND (rem==0); intermediate sub-burst lasts SHALL be suppressed.
REQ-024 SHALL drive master_r_id from the captured id.
REQ-025 SHALL forward a non-zero resp on its own beat unchanged; no sticky error.
REQ-026 SHALL issue exactly one sub-burst with len=0 when len=0.
REQ-027 SHALL end exactly on the last sub-burst when len+1 is an exact multiple of the chunk size; no empty sub-burst is issued.
REQ-028 SHALL raise a simulation $fatal on master AR when burst!=INCR or (1<<size)>DATA_WIDTH/8.
REQ-029 SHALL raise a simulation $fatal when a slave_r_last handshake arrives before the beat count of the current sub-burst.

Reset
REQ-030 SHALL, on rstn low, asynchronously set state=S_IDLE, rem=0 and cur_addr=0.
REQ-031 SHALL hold these outputs low throughout reset: master_ar_ready, slave_ar_valid, master_r_valid, slave_r_ready.
REQ-032 SHALL, on reset mid-transaction, discard the transaction; the first cycle after reset accepts a new AR.

Structure
REQ-033 SHALL take the NastiReq typedef and the chunk-beat function from the shared NASTI package/include (nasti_request.vh).
REQ-034 SHALL be implemented as a single module with no sub-module.

Verification
REQ-035 SHALL cover: MAX_BYTES=128, size=3, addr=0x1000, len=63 -> four sub-bursts of len 15 at 0x1000, 0x1080, 0x1100 and 0x1180; master_r_last only on beat 64.
REQ-036 SHALL cover: addr=0x1040, size=3, len=31 -> sub-bursts at 0x1040 (len 7), 0x1080 (len 15) and 0x1100 (len 7).
REQ-037 SHALL cover: addr=0x1004, size=3, len=0 -> one sub-burst at 0x1004 with len 0; master_r_last on the single beat.
REQ-038 SHALL cover: addr=0x1F80, size=2, len=40 -> sub-bursts 0x1F80 (len 31) and 0x2000 (len 8); no 4KB crossing.
REQ-039 SHALL cover: random master_r_ready/slave_r_valid stalls on the REQ-035 traffic -> all 64 beats delivered in order, no loss or duplication, ready mirrors ready.
REQ-040 SHALL cover: rstn pulsed low during the second sub-burst of REQ-035 -> outputs idle at once; master_ar_ready=1 on the first cycle after release.
